attention_av_matmul: RTL and testbench

- Stage directly downstream of the row-wise softmax approximation. Consumes its normalized attention weights A (L, N, L) and the value matrix V (L, N, D).
- Computes Out[l][n][d] = sum over l2 of A[l][n][l2] * V[l2][n][d] using one signed multiply-accumulate per cycle, with fixed-point rescale and saturation.
- Uses the same flat-bus start/done interface as the softmax stage, so the softmax done/A_out outputs connect directly to this block's start/A_in inputs.

---
 rtl/attention_av_matmul_if.sv | 31 +++
 rtl/attention_av_matmul.sv | 156 +++++++++++++++
 tb/tb_attention_av_matmul.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/attention_av_matmul_if.sv
// Flat-bus start/done interface shared with the softmax stage.
// Latency: n/a (wiring only).
// Backpressure: none; start is a request that the slave may ignore while busy.
interface attention_av_matmul_if #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int D          = 8
);
  localparam int A_BITS = DATA_WIDTH * L * N * L;
  localparam int V_BITS = DATA_WIDTH * L * N * D;
  localparam int O_BITS = DATA_WIDTH * L * N * D;

  logic              start;
  logic [A_BITS-1:0] A_in;
  logic [V_BITS-1:0] V_in;
  logic              busy;
  logic              done;
  logic              out_valid;
  logic [O_BITS-1:0] out_data;

  modport master (
    output start, A_in, V_in,
    input  busy, done, out_valid, out_data
  );

  modport slave (
    input  start, A_in, V_in,
    output busy, done, out_valid, out_data
  );
endinterface

// File: rtl/attention_av_matmul.sv
// Out[l][n][d] = sat((sum_k A[l][n][k]*V[k][n][d]) >>> FRAC_BITS), one MAC per cycle.
// Latency: done pulses 2 + L*N*D*L cycles after start is accepted in idle.
// Backpressure: none; start is ignored while busy or done, no queuing.
module attention_av_matmul #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 15,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int D          = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  attention_av_matmul_if.slave  bus
);
  localparam int A_BITS = DATA_WIDTH * L * N * L;
  localparam int V_BITS = DATA_WIDTH * L * N * D;
  localparam int O_BITS = DATA_WIDTH * L * N * D;
  // Sum of L products of 2*DATA_WIDTH bits cannot overflow this width.
  localparam int ACC_W  = 2 * DATA_WIDTH + $clog2(L);
  localparam int LW     = (L > 1) ? $clog2(L) : 1;
  localparam int NW     = (N > 1) ? $clog2(N) : 1;
  localparam int DW     = (D > 1) ? $clog2(D) : 1;

  localparam logic [LW-1:0] L_LAST = LW'(L - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(D - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_DONE} state_t;

  state_t state, state_nxt;
  logic   busy_c, done_c;

  logic [A_BITS-1:0]       a_lat;
  logic [V_BITS-1:0]       v_lat;
  logic [LW-1:0]           k_cnt, l_cnt;
  logic [NW-1:0]           n_cnt;
  logic [DW-1:0]           d_cnt;
  logic signed [ACC_W-1:0] acc;
  logic                    out_valid_q;
  logic [O_BITS-1:0]       out_data_q;

  int                       a_idx, v_idx, o_idx;
  logic signed [DATA_WIDTH-1:0] a_el, v_el;
  logic signed [ACC_W-1:0]  prod, sum, shifted;
  logic [ACC_W-DATA_WIDTH:0] top_bits;
  logic [DATA_WIDTH-1:0]    sat_val;
  logic                     k_last, elem_last;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_LOAD;
      S_LOAD: begin
        busy_c    = 1'b1;
        state_nxt = S_MAC;
      end
      S_MAC: begin
        busy_c = 1'b1;
        if (elem_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done_c    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand fetch, multiply-accumulate, floor rescale and saturation.
  always_comb begin
    a_idx     = (int'(l_cnt) * N + int'(n_cnt)) * L + int'(k_cnt);
    v_idx     = (int'(k_cnt) * N + int'(n_cnt)) * D + int'(d_cnt);
    o_idx     = (int'(l_cnt) * N + int'(n_cnt)) * D + int'(d_cnt);
    a_el      = a_lat[a_idx*DATA_WIDTH +: DATA_WIDTH];
    v_el      = v_lat[v_idx*DATA_WIDTH +: DATA_WIDTH];
    prod      = a_el * v_el;
    sum       = acc + prod;
    shifted   = sum >>> FRAC_BITS;
    top_bits  = shifted[ACC_W-1:DATA_WIDTH-1];
    // In range when every bit above the result's sign bit matches it.
    if ((&top_bits) || !(|top_bits))
      sat_val = shifted[DATA_WIDTH-1:0];
    else if (shifted[ACC_W-1])
      sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    k_last    = (k_cnt == L_LAST);
    elem_last = k_last && (d_cnt == D_LAST) && (n_cnt == N_LAST) && (l_cnt == L_LAST);
  end

  // Operand latch, loop counters, accumulator and result storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_lat       <= '0;
      v_lat       <= '0;
      k_cnt       <= '0;
      d_cnt       <= '0;
      n_cnt       <= '0;
      l_cnt       <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) out_valid_q <= 1'b0;
        S_LOAD: begin
          a_lat <= bus.A_in;
          v_lat <= bus.V_in;
          k_cnt <= '0;
          d_cnt <= '0;
          n_cnt <= '0;
          l_cnt <= '0;
          acc   <= '0;
        end
        S_MAC: begin
          if (!k_last) begin
            acc   <= sum;
            k_cnt <= k_cnt + 1'b1;
          end else begin
            out_data_q[o_idx*DATA_WIDTH +: DATA_WIDTH] <= sat_val;
            acc   <= '0;
            k_cnt <= '0;
            if (d_cnt != D_LAST) begin
              d_cnt <= d_cnt + 1'b1;
            end else begin
              d_cnt <= '0;
              if (n_cnt != N_LAST) begin
                n_cnt <= n_cnt + 1'b1;
              end else begin
                n_cnt <= '0;
                l_cnt <= l_cnt + 1'b1;
              end
            end
            // Valid is raised together with entry into the done state.
            if (elem_last) out_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_attention_av_matmul.sv
// Bench for attention_av_matmul at L=2, N=1, D=2, Q1.15.
// Latency checked: done exactly 2 + L*N*D*L cycles after accepted start.
// Backpressure exercised: start pulses while busy must be ignored.
module tb_attention_av_matmul;
  localparam int DW   = 16;
  localparam int FRAC = 15;
  localparam int L    = 2;
  localparam int N    = 1;
  localparam int D    = 2;
  localparam int AB   = DW * L * N * L;
  localparam int VB   = DW * L * N * D;
  localparam int OB   = DW * L * N * D;
  localparam int OPS  = L * N * D * L;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  attention_av_matmul_if #(.DATA_WIDTH(DW), .L(L), .N(N), .D(D)) bus ();

  attention_av_matmul #(
    .DATA_WIDTH(DW), .FRAC_BITS(FRAC), .L(L), .N(N), .D(D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: value seen during a cycle equals the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: exact integer dot product, floor division by 2^FRAC, then clamp.
  function automatic logic [OB-1:0] model(input logic [AB-1:0] a, input logic [VB-1:0] v);
    logic [OB-1:0]        r;
    logic signed [DW-1:0] ae, ve;
    longint               s, q, scale, maxv, minv;
    r     = '0;
    scale = longint'(1) << FRAC;
    maxv  = (longint'(1) << (DW - 1)) - 1;
    minv  = -(longint'(1) << (DW - 1));
    for (int l = 0; l < L; l++)
      for (int n = 0; n < N; n++)
        for (int d = 0; d < D; d++) begin
          s = 0;
          for (int k = 0; k < L; k++) begin
            ae = a[((l*N+n)*L+k)*DW +: DW];
            ve = v[((k*N+n)*D+d)*DW +: DW];
            s  = s + longint'(ae) * longint'(ve);
          end
          if (s >= 0) q = s / scale;
          else        q = -((-s + scale - 1) / scale);
          if (q > maxv) q = maxv;
          if (q < minv) q = minv;
          r[((l*N+n)*D+d)*DW +: DW] = q[DW-1:0];
        end
    return r;
  endfunction

  // One full operation; optionally pokes start with other operands at t0+poke_at.
  task automatic do_op(input string tag, input logic [AB-1:0] a, input logic [VB-1:0] v,
                       input logic [OB-1:0] exp, input int poke_at);
    int t0, done_cyc, done_cnt;
    @(negedge clk);
    bus.A_in  = a;
    bus.V_in  = v;
    bus.start = 1'b1;
    t0        = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_valid_clr"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    done_cyc = -1;
    done_cnt = 0;
    for (int i = 0; i < OPS + 6; i++) begin
      if (poke_at > 0 && cyc == t0 + poke_at) begin
        bus.start = 1'b1;
        bus.A_in  = ~a;
        bus.V_in  = v ^ {$urandom, $urandom};
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(t0 + 2 + OPS));
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_data"}, bus.out_data, exp);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  logic [AB-1:0] ra;
  logic [VB-1:0] rv;
  int            t_rst;

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A_in  = '0;
    bus.V_in  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", bus.out_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases with hand-derived results.
    do_op("basic", 64'h7FFF_0000_4000_4000, 64'h0000_6000_1000_2000,
          64'h0000_5FFF_0800_4000, 0);
    do_op("pos_sat", 64'h0000_0000_7FFF_7FFF, 64'h0000_7FFF_0000_7FFF,
          64'h0000_0000_0000_7FFF, 0);
    do_op("neg_sat", 64'h0000_0000_8000_8000, 64'h0000_7FFF_0000_7FFF,
          64'h0000_0000_0000_8000, 0);
    do_op("floor", 64'h0000_0000_0000_4000, 64'h0000_0000_0000_FFFF,
          64'h0000_0000_0000_FFFF, 0);

    // Start pulse mid-operation must not disturb the running result.
    ra = {$urandom, $urandom};
    rv = {$urandom, $urandom};
    do_op("busy_start", ra, rv, model(ra, rv), 5);
    ra = {$urandom, $urandom};
    rv = {$urandom, $urandom};
    do_op("after_busy", ra, rv, model(ra, rv), 0);

    // Reset in the middle of an operation.
    @(negedge clk);
    bus.A_in  = {$urandom, $urandom};
    bus.V_in  = {$urandom, $urandom};
    bus.start = 1'b1;
    t_rst     = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20 && cyc < t_rst + 6; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_data", bus.out_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_still_idle", 64'(bus.done | bus.busy), 64'd0);
    ra = {$urandom, $urandom};
    rv = {$urandom, $urandom};
    do_op("post_rst", ra, rv, model(ra, rv), 0);

    // Randomized operands; alternate full-range and small-magnitude weights.
    for (int it = 0; it < 10; it++) begin
      ra = {$urandom, $urandom};
      rv = {$urandom, $urandom};
      if (it % 2 == 1) ra = ra & 64'h1FFF_1FFF_1FFF_1FFF;
      do_op($sformatf("rand%0d", it), ra, rv, model(ra, rv), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
